// File: rtl/fetch_inst_queue.sv
// Decoupling queue between fetch and decode: a circular buffer holding instruction, PC,
// compressed flag and branch prediction, with a one-cycle flush for mispredicts.
module fetch_inst_queue #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         flush_i,
    input  logic                         enq_valid_i,
    output logic                         enq_ready_o,
    input  logic [XLEN-1:0]              enq_inst_i,
    input  logic [XLEN-1:0]              enq_pc_i,
    input  logic                         enq_is_comp_i,
    input  logic                         enq_spec_taken_i,
    input  logic [XLEN-1:0]              enq_spec_pc_i,
    input  logic                         deq_ready_i,
    output logic                         deq_valid_o,
    output logic [XLEN-1:0]              inst_o,
    output logic [XLEN-1:0]              pc_o,
    output logic                         is_comp_o,
    output logic                         spec_taken_o,
    output logic [XLEN-1:0]              spec_pc_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam logic [CntW-1:0] CountFull = CntW'(DEPTH);
    localparam logic [XLEN-1:0] InstNop   = XLEN'(32'h0000_0013);

    logic [XLEN-1:0] inst_mem     [DEPTH];
    logic [XLEN-1:0] pc_mem       [DEPTH];
    logic [XLEN-1:0] spec_pc_mem  [DEPTH];
    logic            is_comp_mem  [DEPTH];
    logic            spec_tkn_mem [DEPTH];

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;

    logic full, empty, enq_fire, deq_fire;

    assign full  = (count_q == CountFull);
    assign empty = (count_q == '0);

    always_comb begin
        enq_fire = enq_valid_i && !full && !flush_i;
        deq_fire = !empty && deq_ready_i && !flush_i;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointer width matches DEPTH (power of two), so the adds wrap for free.
            if (enq_fire) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (deq_fire) rd_ptr_d = rd_ptr_q + PtrW'(1);
            case ({enq_fire, deq_fire})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq_fire) begin
            inst_mem[wr_ptr_q]     <= enq_inst_i;
            pc_mem[wr_ptr_q]       <= enq_pc_i;
            spec_pc_mem[wr_ptr_q]  <= enq_spec_pc_i;
            is_comp_mem[wr_ptr_q]  <= enq_is_comp_i;
            spec_tkn_mem[wr_ptr_q] <= enq_spec_taken_i;
        end
    end

    // Empty queue presents a NOP with a zeroed payload so stale entries never leak out.
    always_comb begin
        inst_o       = InstNop;
        pc_o         = '0;
        spec_pc_o    = '0;
        is_comp_o    = 1'b0;
        spec_taken_o = 1'b0;
        if (!empty) begin
            inst_o       = inst_mem[rd_ptr_q];
            pc_o         = pc_mem[rd_ptr_q];
            spec_pc_o    = spec_pc_mem[rd_ptr_q];
            is_comp_o    = is_comp_mem[rd_ptr_q];
            spec_taken_o = spec_tkn_mem[rd_ptr_q];
        end
    end

    assign enq_ready_o = !full;
    assign deq_valid_o = !empty;
    assign count_o     = count_q;

endmodule

// File: tb/tb_fetch_inst_queue.sv
// Directed bench for fetch_inst_queue: reset, fill/drain, wrap-around, flush and prediction.
module tb_fetch_inst_queue;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        flush_i = 1'b0;
    logic        enq_valid_i = 1'b0;
    logic        enq_ready_o;
    logic [31:0] enq_inst_i = '0;
    logic [31:0] enq_pc_i = '0;
    logic        enq_is_comp_i = 1'b0;
    logic        enq_spec_taken_i = 1'b0;
    logic [31:0] enq_spec_pc_i = '0;
    logic        deq_ready_i = 1'b0;
    logic        deq_valid_o;
    logic [31:0] inst_o, pc_o, spec_pc_o;
    logic        is_comp_o, spec_taken_o;
    logic [2:0]  count_o;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_inst_queue #(.XLEN(32), .DEPTH(4)) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .flush_i          (flush_i),
        .enq_valid_i      (enq_valid_i),
        .enq_ready_o      (enq_ready_o),
        .enq_inst_i       (enq_inst_i),
        .enq_pc_i         (enq_pc_i),
        .enq_is_comp_i    (enq_is_comp_i),
        .enq_spec_taken_i (enq_spec_taken_i),
        .enq_spec_pc_i    (enq_spec_pc_i),
        .deq_ready_i      (deq_ready_i),
        .deq_valid_o      (deq_valid_o),
        .inst_o           (inst_o),
        .pc_o             (pc_o),
        .is_comp_o        (is_comp_o),
        .spec_taken_o     (spec_taken_o),
        .spec_pc_o        (spec_pc_o),
        .count_o          (count_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return {pc[15:0], 16'h0533};
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_enq(input logic v, input logic [31:0] pc, input logic comp,
                           input logic tkn, input logic [31:0] tpc);
        enq_valid_i      = v;
        enq_pc_i         = pc;
        enq_inst_i       = inst_of(pc);
        enq_is_comp_i    = comp;
        enq_spec_taken_i = tkn;
        enq_spec_pc_i    = tpc;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        flush_i = 1'b0;
        deq_ready_i = 1'b0;
        set_enq(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        rst_ni = 1'b1;
    endtask

    task automatic fill4();
        deq_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_enq(1'b1, 32'h4000_0000 + 32'(i * 4), i[0], 1'b0, 32'h0);
            tick();
        end
        set_enq(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_enq(1'b1, 32'h4000_1000 + 32'(i * 4), 1'b0, 1'b0, 32'h0);
            tick();
        end
        set_enq(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        if (count_o !== 3'd3) begin
            $display("FAIL reset_pre_count: got %0d want 3", count_o); n_fail++;
        end
        n_checks++;
        #2 rst_ni = 1'b0;
        #1;
        if (count_o !== 3'd0) begin
            $display("FAIL reset_count: got %0d want 0", count_o); n_fail++;
        end
        n_checks++;
        if (deq_valid_o !== 1'b0) begin
            $display("FAIL reset_deq_valid: got %b want 0", deq_valid_o); n_fail++;
        end
        n_checks++;
        if (inst_o !== 32'h13) begin
            $display("FAIL reset_inst: got %h want 00000013", inst_o); n_fail++;
        end
        n_checks++;
        if (enq_ready_o !== 1'b1) begin
            $display("FAIL reset_enq_ready: got %b want 1", enq_ready_o); n_fail++;
        end
        n_checks++;
        if ({pc_o, spec_pc_o, is_comp_o, spec_taken_o} !== 66'h0) begin
            $display("FAIL reset_payload: pc %h spc %h comp %b tkn %b want zeros",
                     pc_o, spec_pc_o, is_comp_o, spec_taken_o); n_fail++;
        end
        n_checks++;
        tick();
        rst_ni = 1'b1;
    endtask

    task automatic test_fill_drain();
        logic [31:0] pcs [4];
        logic        comp [4];
        pcs[0] = 32'h4000_0000; pcs[1] = 32'h4000_0004;
        pcs[2] = 32'h4000_0006; pcs[3] = 32'h4000_000A;
        comp[0] = 1'b0; comp[1] = 1'b1; comp[2] = 1'b0; comp[3] = 1'b1;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_enq(1'b1, pcs[i], comp[i], 1'b0, 32'h0);
            tick();
        end
        if (count_o !== 3'd4 || enq_ready_o !== 1'b0) begin
            $display("FAIL fill_full: count %0d ready %b want 4 0", count_o, enq_ready_o);
            n_fail++;
        end
        n_checks++;
        set_enq(1'b1, 32'h4000_0010, 1'b0, 1'b0, 32'h0);
        tick();
        if (count_o !== 3'd4) begin
            $display("FAIL fifth_rejected: count %0d want 4", count_o); n_fail++;
        end
        n_checks++;
        set_enq(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        deq_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (pc_o !== pcs[i] || is_comp_o !== comp[i] || inst_o !== inst_of(pcs[i])) begin
                $display("FAIL drain_%0d: pc %h comp %b inst %h want %h %b %h", i, pc_o,
                         is_comp_o, inst_o, pcs[i], comp[i], inst_of(pcs[i]));
                n_fail++;
            end
            n_checks++;
            tick();
        end
        deq_ready_i = 1'b0;
        if (count_o !== 3'd0 || deq_valid_o !== 1'b0 || inst_o !== 32'h13) begin
            $display("FAIL drain_empty: count %0d valid %b inst %h want 0 0 00000013",
                     count_o, deq_valid_o, inst_o); n_fail++;
        end
        n_checks++;
    endtask

    task automatic test_wrap();
        logic [31:0] base;
        base = 32'h4000_2000;
        do_reset();
        deq_ready_i = 1'b1;
        set_enq(1'b1, base, 1'b0, 1'b0, 32'h0);
        tick();
        for (int i = 1; i < 10; i++) begin
            if (count_o !== 3'd1 || pc_o !== base + 32'((i - 1) * 4)) begin
                $display("FAIL wrap_%0d: count %0d pc %h want 1 %h", i, count_o, pc_o,
                         base + 32'((i - 1) * 4)); n_fail++;
            end
            n_checks++;
            set_enq(1'b1, base + 32'(i * 4), 1'b0, 1'b0, 32'h0);
            tick();
        end
        set_enq(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        if (count_o !== 3'd1 || pc_o !== base + 32'd36) begin
            $display("FAIL wrap_last: count %0d pc %h want 1 %h", count_o, pc_o, base + 32'd36);
            n_fail++;
        end
        n_checks++;
        tick();
        deq_ready_i = 1'b0;
        if (count_o !== 3'd0) begin
            $display("FAIL wrap_empty: count %0d want 0", count_o); n_fail++;
        end
        n_checks++;
    endtask

    task automatic test_flush_full();
        do_reset();
        fill4();
        flush_i = 1'b1;
        set_enq(1'b1, 32'h4000_0100, 1'b0, 1'b0, 32'h0);
        tick();
        flush_i = 1'b0;
        set_enq(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        if (count_o !== 3'd0 || deq_valid_o !== 1'b0 || enq_ready_o !== 1'b1) begin
            $display("FAIL flush_full: count %0d valid %b ready %b want 0 0 1", count_o,
                     deq_valid_o, enq_ready_o); n_fail++;
        end
        n_checks++;
        set_enq(1'b1, 32'h4000_0200, 1'b0, 1'b0, 32'h0);
        tick();
        set_enq(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        if (deq_valid_o !== 1'b1 || pc_o !== 32'h4000_0200 || count_o !== 3'd1) begin
            $display("FAIL flush_refill: valid %b pc %h count %0d want 1 40000200 1",
                     deq_valid_o, pc_o, count_o); n_fail++;
        end
        n_checks++;
    endtask

    task automatic test_full_deq();
        do_reset();
        fill4();
        deq_ready_i = 1'b1;
        tick();
        deq_ready_i = 1'b0;
        if (count_o !== 3'd3 || enq_ready_o !== 1'b1 || pc_o !== 32'h4000_0004) begin
            $display("FAIL full_deq: count %0d ready %b pc %h want 3 1 40000004", count_o,
                     enq_ready_o, pc_o); n_fail++;
        end
        n_checks++;
        flush_i = 1'b1;
        deq_ready_i = 1'b1;
        tick();
        flush_i = 1'b0;
        deq_ready_i = 1'b0;
        if (count_o !== 3'd0) begin
            $display("FAIL flush_with_deq: count %0d want 0", count_o); n_fail++;
        end
        n_checks++;
    endtask

    task automatic test_prediction();
        do_reset();
        set_enq(1'b1, 32'h4000_0030, 1'b0, 1'b1, 32'h4000_0040);
        tick();
        set_enq(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        if (spec_taken_o !== 1'b1 || spec_pc_o !== 32'h4000_0040) begin
            $display("FAIL pred_head: tkn %b spc %h want 1 40000040", spec_taken_o, spec_pc_o);
            n_fail++;
        end
        n_checks++;
        deq_ready_i = 1'b1;
        tick();
        deq_ready_i = 1'b0;
        if (spec_taken_o !== 1'b0 || spec_pc_o !== 32'h0 || deq_valid_o !== 1'b0) begin
            $display("FAIL pred_empty: tkn %b spc %h valid %b want 0 0 0", spec_taken_o,
                     spec_pc_o, deq_valid_o); n_fail++;
        end
        n_checks++;
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_wrap();
        test_flush_full();
        test_full_deq();
        test_prediction();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_inst_queue.md
# fetch_inst_queue

Decoupling instruction queue between stage1_fetch and stage2_decode. Each entry holds the fetched instruction, its PC, the compressed flag, and the branch prediction made for it. Fetch can run ahead while decode is stalled; the backpressure output drives fetch's `fe_stall_i`. A mispredict flush empties the queue in one cycle.

## Interface
- `XLEN`, 32, data/address width.
- `DEPTH`, 4, number of entries; a power of two, ≥ 2.
- `clk_i` in 1: single clock, all state on rising edge.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `flush_i` in 1: discard all entries, e.g. on mispredict (`spec_hit` low).
- `enq_valid_i` in 1: fetch presents a valid instruction (`!imiss_stall_o`).
- `enq_ready_o` out 1: queue can accept; equals `!full`. Fetch stall = `!enq_ready_o`.
- `enq_inst_i` in XLEN: expanded 32-bit instruction.
- `enq_pc_i` in XLEN: instruction PC.
- `enq_is_comp_i` in 1: original encoding was 16-bit.
- `enq_spec_taken_i` in 1: predictor said taken.
- `enq_spec_pc_i` in XLEN: predicted target.
- `deq_ready_i` in 1: decode accepts the head this cycle.
- `deq_valid_o` out 1: head entry is valid.
- `inst_o`, `pc_o` out XLEN: head instruction and its PC.
- `is_comp_o`, `spec_taken_o` out 1: head compressed flag and head prediction.
- `spec_pc_o` out XLEN: head predicted target.
- `count_o` out $clog2(DEPTH+1): number of occupied entries.

## Operation
- Circular buffer with `wr_ptr` and `rd_ptr`, each $clog2(DEPTH) bits, plus `count`.
- Pointers wrap modulo DEPTH and increment by 1.
- `full` = (`count` == DEPTH). `empty` = (`count` == 0).
- Enqueue fire = `enq_valid_i && enq_ready_o && !flush_i`.
  - Writes the payload at `wr_ptr`.
  - Increments `wr_ptr`.
- Dequeue fire = `deq_valid_o && deq_ready_i && !flush_i`.
  - Increments `rd_ptr`.
- Count update:
  - `count` +1 on enqueue only.
  - `count` −1 on dequeue only.
  - Unchanged when both or neither fire.
- `enq_ready_o` = `!full`. There is no same-cycle pass-through when full, so there is no combinational path from `deq_ready_i` to `enq_ready_o`.
- No empty-bypass: an entry is visible at the head only the cycle after it is written.
- `deq_valid_o` = `!empty`.
- Head payload comes from the entry at `rd_ptr`.
- When empty, outputs are forced:
  - `inst_o` = 32'h0000_0013 (NOP).
  - `pc_o` = 0, `spec_pc_o` = 0.
  - `is_comp_o` = 0, `spec_taken_o` = 0.
- Flush:
  - Next cycle: `wr_ptr` = `rd_ptr` = `count` = 0.
  - Any same-cycle enqueue or dequeue is ignored.
  - Flush has priority over everything except reset.
- Storage arrays need no reset. Pointers and count are reset.
- No FSM; the state is pointers plus count. Behaviour is fully determined by `count` ∈ [0, DEPTH].

## Timing
- Reset (`rst_ni` low, asynchronous) clears `wr_ptr`, `rd_ptr` and `count` immediately. Values while in reset:
  - `deq_valid_o` = 0, `enq_ready_o` = 1, `count_o` = 0.
  - `inst_o` = 32'h13, every other payload output 0.
- Reset asserted mid-operation drops all entries with no handshake.
- Release is synchronous to `clk_i`: the first enqueue may occur on the first rising edge with `rst_ni` high.
- Latency enqueue → `deq_valid_o`: 1 cycle.
- Throughput: 1 enqueue and 1 dequeue per cycle sustained whenever 0 < `count` < DEPTH.
- Full + `deq_ready_i`: dequeue fires. `enq_ready_o` rises the next cycle.
- Empty + `enq_valid_i` + `deq_ready_i`: enqueue only. The head becomes valid the next cycle.
- Flush + full + `enq_valid_i`: queue is empty the next cycle and `enq_ready_o` = 1. The offered instruction is lost; fetch redirects anyway.
- Outputs depend only on registered state; there is no input→output combinational path.

## Test plan
- Reset check: hold `rst_ni`=0 mid-stream with `count`=3 → `count_o`=0, `deq_valid_o`=0, `inst_o`=32'h13, `enq_ready_o`=1, all within the reset cycle (asynchronous).
- Fill and drain: `deq_ready_i`=0, enqueue PCs 0x4000_0000, 0x4000_0004, 0x4000_0006, 0x4000_000A. Then:
  - `count_o`=4 and `enq_ready_o`=0.
  - A fifth `enq_valid_i` is not accepted.
  - Raise `deq_ready_i` → PCs leave in order 0x…00, 0x…04, 0x…06, 0x…0A; `is_comp_o`=0,1,0,x as enqueued.
- Wrap-around: stream 10 instructions with `enq_valid_i`=`deq_ready_i`=1 continuously → `count_o` stays at 1 after the first cycle and the output order matches the input order across two pointer wraps.
- Flush while full:
  - Setup: `count_o`=4, then assert `flush_i` with `enq_valid_i`=1 carrying PC 0x4000_0100.
  - Next cycle: `count_o`=0, `deq_valid_o`=0.
  - Subsequent enqueue of 0x4000_0200 → it appears at the head one cycle later.
- Full with dequeue: at `count_o`=4 pulse `deq_ready_i` → `count_o`=3 and `enq_ready_o`=1 next cycle; no enqueue in the pulse cycle.
- Prediction payload: enqueue `spec_taken`=1, `spec_pc`=0x4000_0040 → head shows `spec_taken_o`=1, `spec_pc_o`=0x4000_0040; after dequeue and empty, both read 0.
